// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, types and constants for the integer register file
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    // x0 is hardwired to zero; its address is never written and always reads 0
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port: address mux, x0 masking, optional bypass
// Optional feature: REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                                       rst,
    input  logic [ADDR_WIDTH-1:0]                      addr,
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
`ifdef REGFILE_BYPASS_EN
    input  logic                                       wen,
    input  logic [ADDR_WIDTH-1:0]                      wa,
    input  logic [DATA_WIDTH-1:0]                      wd,
`endif
    output logic [DATA_WIDTH-1:0]                      rdata
);

    always_comb begin
        rdata = regs[addr];
        // Reset and x0 both force zero, so an uninitialised entry can never leak out
        if (rst || (addr == ADDR_WIDTH'(REG_ZERO))) begin
            rdata = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wen && (addr == wa)) begin
            rdata = wd;
        end
`endif
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 RISC-V integer register file, two async read ports, one sync write port
// Optional feature: REGFILE_BYPASS_EN forwards wd to a read port addressing wa in the same cycle.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;

    // Entry 0 is reloaded with zero every cycle so it reduces to a constant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
            regs[0] <= '0;
            if (wen && (wa != ADDR_WIDTH'(REG_ZERO))) begin
                regs[wa] <= wd;
            end
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port1 (
        .rst   (rst),
        .addr  (ra1),
        .regs  (regs),
`ifdef REGFILE_BYPASS_EN
        .wen   (wen),
        .wa    (wa),
        .wd    (wd),
`endif
        .rdata (rd1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port2 (
        .rst   (rst),
        .addr  (ra2),
        .regs  (regs),
`ifdef REGFILE_BYPASS_EN
        .wen   (wen),
        .wa    (wa),
        .wd    (wd),
`endif
        .rdata (rd2)
    );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file (honours REGFILE_BYPASS_EN)
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] rd1;
    logic [31:0] rd2;

    logic [31:0] model [32];
    logic [31:0] sb_q [$];

    int checks;
    int failures;

    register_file dut (
        .clk (clk),
        .rst (rst),
        .wen (wen),
        .ra1 (ra1),
        .ra2 (ra2),
        .wa  (wa),
        .wd  (wd),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wen && a == wa) return wd;
`endif
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Expected values go into the scoreboard as the addresses are driven
    task automatic read_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] e;
        ra1 = a1;
        ra2 = a2;
        sb_q.push_back(exp_read(a1));
        sb_q.push_back(exp_read(a2));
        #1;
        e = sb_q.pop_front();
        check({tag, "_rd1"}, rd1, e);
        e = sb_q.pop_front();
        check({tag, "_rd2"}, rd2, e);
    endtask

    task automatic step();
        if (!rst && wen && wa != 5'd0) model[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wen = 1'b1;
        wa  = a;
        wd  = d;
        step();
        wen = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_model();
        rst = 1'b1;
        wen = 1'b0;
        wa  = '0;
        wd  = '0;
        ra1 = '0;
        ra2 = '0;

        read_pair("reset_init", 5'd0, 5'd1);
        @(negedge clk);
        rst = 1'b0;

        // Load everything with DEADBEEF, then reset asynchronously between edges
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hDEADBEEF);
        read_pair("preload", 5'd1, 5'd31);
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        for (int i = 0; i < 32; i++) read_pair("reset_all", 5'(i), 5'(31 - i));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
        for (int i = 0; i < 32; i++) read_pair("fill", 5'(i), 5'(i));

        write_reg(5'd0, 32'hFFFFFFFF);
        read_pair("x0_write", 5'd0, 5'd0);

        wen = 1'b0;
        wa  = 5'd5;
        wd  = 32'h12345678;
        step();
        read_pair("wen_low", 5'd0, 5'd5);

        // Same-cycle read of the register being written
        wen = 1'b1;
        wa  = 5'd7;
        wd  = 32'hA5A5A5A5;
        read_pair("same_cycle_pre", 5'd7, 5'd6);
        step();
        wen = 1'b0;
        read_pair("same_cycle_post", 5'd7, 5'd6);

        wen = 1'b1;
        wa  = 5'd0;
        wd  = 32'h5A5A5A5A;
        read_pair("x0_bypass", 5'd0, 5'd0);
        step();
        wen = 1'b0;

        for (int n = 0; n < 300; n++) begin
            wen = 1'($urandom_range(0, 1));
            wa  = 5'($urandom);
            wd  = $urandom;
            if (n % 4 == 0) read_pair("rand_hit", wa, 5'($urandom));
            else            read_pair("rand", 5'($urandom), 5'($urandom));
            step();
        end
        wen = 1'b0;
        for (int i = 0; i < 32; i++) read_pair("rand_final", 5'(i), 5'(31 - i));

        // Asynchronous reset between edges with a write pending
        write_reg(5'd3, 32'h33);
        #2;
        wen = 1'b1;
        wa  = 5'd3;
        wd  = 32'd9;
        rst = 1'b1;
        clear_model();
        read_pair("rst_async", 5'd3, 5'd4);
        step();
        read_pair("rst_edge", 5'd3, 5'd3);
        @(negedge clk);
        rst = 1'b0;
        wen = 1'b0;
        read_pair("rst_release", 5'd3, 5'd0);
        write_reg(5'd3, 32'd9);
        read_pair("rst_resume", 5'd3, 5'd4);

        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
